// File: rtl/hazard_fwd_ctrl_pkg.sv
// ============================================================================
// hazard_fwd_ctrl_pkg : shared encodings for the hazard/forwarding controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_fwd_ctrl_pkg;

    localparam int c_REG_AW_DEFAULT = 5;

    localparam logic [1:0] c_FWD_RF    = 2'b00;
    localparam logic [1:0] c_FWD_MEMWB = 2'b01;
    localparam logic [1:0] c_FWD_EXMEM = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BUBBLE   = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_ctrl_if.sv
// ============================================================================
// hazard_fwd_ctrl_if : pipeline-side signal bundle of the hazard controller
// Revision: 1.0
// ============================================================================
`default_nettype none

interface hazard_fwd_ctrl_if
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW = c_REG_AW_DEFAULT,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs1, id_rs2;
    logic              id_use_rs1, id_use_rs2;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic              ex_regwrite, ex_memread;
    logic [REG_AW-1:0] exmem_rd;
    logic              exmem_regwrite, exmem_memreq;
    logic [REG_AW-1:0] memwb_rd;
    logic              memwb_regwrite;
    logic              mem_ready;
    logic              perf_clr;
    logic [1:0]        fwd_a, fwd_b;
    logic              stall_pc, stall_ifid, stall_idex, stall_exmem;
    logic              bubble_idex, bubble_memwb;
    logic [CNT_W-1:0]  lu_cnt, mem_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_regwrite, ex_memread, exmem_rd, exmem_regwrite, exmem_memreq,
               memwb_rd, memwb_regwrite, mem_ready, perf_clr,
        input  fwd_a, fwd_b, stall_pc, stall_ifid, stall_idex, stall_exmem,
               bubble_idex, bubble_memwb, lu_cnt, mem_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_regwrite, ex_memread, exmem_rd, exmem_regwrite, exmem_memreq,
               memwb_rd, memwb_regwrite, mem_ready, perf_clr,
        output fwd_a, fwd_b, stall_pc, stall_ifid, stall_idex, stall_exmem,
               bubble_idex, bubble_memwb, lu_cnt, mem_cnt
    );
endinterface

`default_nettype wire

// File: rtl/hazard_fwd_ctrl_fwd_select.sv
// ============================================================================
// hazard_fwd_ctrl_fwd_select : forwarding-source select for one ALU operand
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_ctrl_fwd_select
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW  = c_REG_AW_DEFAULT,
    parameter bit X0_ZERO = 1'b1
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic              i_exmem_regwrite,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic              i_memwb_regwrite,
    output logic [1:0]        o_sel
);
    logic w_exmem_hit;
    logic w_memwb_hit;

    assign w_exmem_hit = i_exmem_regwrite && (i_exmem_rd == i_src)
                         && !(X0_ZERO && (i_exmem_rd == '0));
    assign w_memwb_hit = i_memwb_regwrite && (i_memwb_rd == i_src)
                         && !(X0_ZERO && (i_memwb_rd == '0));

    // The younger producer in EX/MEM holds the newest value.
    always_comb begin
        o_sel = c_FWD_RF;
        if (w_exmem_hit) begin
            o_sel = c_FWD_EXMEM;
        end else if (w_memwb_hit) begin
            o_sel = c_FWD_MEMWB;
        end
    end
endmodule

`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
// ============================================================================
// hazard_fwd_ctrl : EX operand forwarding, load-use bubbles, memory-wait
//                   freeze and saturating stall counters
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW   = c_REG_AW_DEFAULT,
    parameter int LOAD_LAT = 1,
    parameter bit X0_ZERO  = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    hazard_fwd_ctrl_if.slave  bus
);
    localparam logic [1:0]       c_BCNT_INIT = 2'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    state_e            r_state, w_state_nxt, w_eff_state;
    logic [1:0]        r_bcnt, w_bcnt_nxt;
    logic [REG_AW-1:0] r_lu_rd, w_lu_rd_nxt;
    logic              r_ret_bubble, w_ret_nxt;
    logic              w_lu_hit, w_mw_hit, w_mem_done;
    logic              w_freeze, w_bubble;
    logic              w_freeze_o, w_bubble_o;
    logic [CNT_W-1:0]  r_lu_cnt, r_mem_cnt;

    hazard_fwd_ctrl_fwd_select #(.REG_AW(REG_AW), .X0_ZERO(X0_ZERO)) u_fwd_select_a (
        .i_src            (bus.ex_rs1),
        .i_exmem_rd       (bus.exmem_rd),
        .i_exmem_regwrite (bus.exmem_regwrite),
        .i_memwb_rd       (bus.memwb_rd),
        .i_memwb_regwrite (bus.memwb_regwrite),
        .o_sel            (bus.fwd_a)
    );

    hazard_fwd_ctrl_fwd_select #(.REG_AW(REG_AW), .X0_ZERO(X0_ZERO)) u_fwd_select_b (
        .i_src            (bus.ex_rs2),
        .i_exmem_rd       (bus.exmem_rd),
        .i_exmem_regwrite (bus.exmem_regwrite),
        .i_memwb_rd       (bus.memwb_rd),
        .i_memwb_regwrite (bus.memwb_regwrite),
        .o_sel            (bus.fwd_b)
    );

    assign w_lu_hit = bus.ex_memread && bus.ex_regwrite
                      && !(X0_ZERO && (bus.ex_rd == '0))
                      && ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd))
                       || (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
    assign w_mw_hit   = bus.exmem_memreq && !bus.mem_ready;
    assign w_mem_done = bus.exmem_memreq && bus.mem_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_bcnt       <= '0;
            r_lu_rd      <= '0;
            r_ret_bubble <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bcnt       <= w_bcnt_nxt;
            r_lu_rd      <= w_lu_rd_nxt;
            r_ret_bubble <= w_ret_nxt;
        end
    end

    // On the ready cycle the return state's rules already apply, so a bubble
    // displaced by the freeze is issued then and the total stays LOAD_LAT.
    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_lu_rd_nxt = r_lu_rd;
        w_ret_nxt   = r_ret_bubble;
        w_freeze    = 1'b0;
        w_bubble    = 1'b0;
        w_eff_state = ST_RUN;
        if ((r_state == ST_BUBBLE) || ((r_state == ST_MEM_WAIT) && r_ret_bubble)) begin
            w_eff_state = ST_BUBBLE;
        end

        if ((r_state == ST_MEM_WAIT) && !w_mem_done) begin
            w_freeze = 1'b1;
        end else begin
            w_state_nxt = w_eff_state;
            if (w_mw_hit) begin
                w_freeze    = 1'b1;
                w_state_nxt = ST_MEM_WAIT;
                w_ret_nxt   = (w_eff_state == ST_BUBBLE);
            end else if (w_eff_state == ST_BUBBLE) begin
                w_bubble   = 1'b1;
                w_bcnt_nxt = r_bcnt - 2'd1;
                if (r_bcnt == 2'd1) begin
                    w_state_nxt = ST_RUN;
                end
            end else if (w_lu_hit) begin
                w_bubble = 1'b1;
                if (LOAD_LAT > 1) begin
                    w_lu_rd_nxt = bus.ex_rd;
                    w_bcnt_nxt  = c_BCNT_INIT;
                    w_state_nxt = ST_BUBBLE;
                end
            end
        end
    end

    assign w_freeze_o       = w_freeze && !reset;
    assign w_bubble_o       = w_bubble && !reset;
    assign bus.stall_pc     = w_freeze_o || w_bubble_o;
    assign bus.stall_ifid   = w_freeze_o || w_bubble_o;
    assign bus.stall_idex   = w_freeze_o;
    assign bus.stall_exmem  = w_freeze_o;
    assign bus.bubble_idex  = w_bubble_o;
    assign bus.bubble_memwb = w_freeze_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lu_cnt  <= '0;
            r_mem_cnt <= '0;
        end else if (bus.perf_clr) begin
            r_lu_cnt  <= '0;
            r_mem_cnt <= '0;
        end else begin
            if (w_bubble_o && (r_lu_cnt != '1)) begin
                r_lu_cnt <= r_lu_cnt + c_CNT_ONE;
            end
            if (w_freeze_o && (r_mem_cnt != '1)) begin
                r_mem_cnt <= r_mem_cnt + c_CNT_ONE;
            end
        end
    end

    assign bus.lu_cnt  = r_lu_cnt;
    assign bus.mem_cnt = r_mem_cnt;

    // A multi-cycle bubble is only ever started by a real (non-x0) load target.
    a_lu_rd_live : assert property (@(posedge clk) disable iff (reset)
        ((r_state == ST_BUBBLE) && X0_ZERO) |-> (r_lu_rd != '0));
endmodule

`default_nettype wire
